exception_ctrl: RTL and testbench
=================================

EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 Parameter N_SRC, default 3, SHALL set the number of exception sources; index 0 has the highest priority.
REQ-002 Parameter W, default 32, SHALL set the PC/address width.
REQ-003 Parameter VEC_BASE, default 253, SHALL set the vector-table byte address of source 0; source i uses VEC_BASE+i.
REQ-004 Parameter MEM_LAT, default 2, minimum 1, SHALL set the cycles from the mem_rd strobe to valid mem_data.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset_n  in  1  reset, synchronous, active-low.
REQ-007 exc_in  in  N_SRC  exception request per source, pulse or level.
REQ-008 exc_mask  in  N_SRC  per-source enable, 1=enabled.
REQ-009 pc_in  in  W  address of the faulting instruction.
REQ-010 mem_data  in  8  byte returned from the vector table.
REQ-011 rte  in  1  return-from-exception pulse.
REQ-012 mem_rd  out  1  one-cycle vector read strobe.
REQ-013 mem_addr  out  W  vector byte address.
REQ-014 epc  out  W  saved PC.
REQ-015 cause  out  N_SRC  one-hot code of the served source.
REQ-016 new_pc  out  W  PC value to load.
REQ-017 pc_load  out  1  one-cycle strobe: the PC takes new_pc.
REQ-018 exc_active  out  1  1 in every state except IDLE (stall for control unit).
REQ-019 pending  out  N_SRC  latched, unserved requests.

Function
REQ-020 The FSM SHALL have states IDLE, FETCH, WAIT, LOAD, HANDLER and RETURN; all outputs SHALL be registered.
REQ-021 pending[i] SHALL set on any cycle with exc_in[i]&exc_mask[i]=1; masked requests SHALL be discarded and SHALL NOT fire on later unmasking.
REQ-022 In IDLE, if pending|(exc_in&exc_mask) is non-zero, the FSM SHALL select the lowest set index i, latch epc<=pc_in, cause<=onehot(i) and mem_addr<=VEC_BASE+i (mod 2^W), clear pending[i], and go to FETCH.
REQ-023 If source i asserts again in its selection cycle, the set SHALL win and pending[i] SHALL remain 1.
REQ-024 In FETCH, mem_rd SHALL be 1 for exactly one cycle, a down-counter SHALL load MEM_LAT-1, and the FSM SHALL go to WAIT.
REQ-025 In WAIT, the FSM SHALL decrement the counter; at 0 (exactly MEM_LAT cycles after mem_rd) it SHALL set new_pc<=zero-extended mem_data and go to LOAD.
REQ-026 In LOAD, pc_load SHALL be 1 for one cycle, and the FSM SHALL go to HANDLER.
REQ-027 In HANDLER, there SHALL be no nesting: new requests only accumulate in pending, and rte SHALL set new_pc<=epc and go to RETURN.
REQ-028 In RETURN, pc_load SHALL be 1 for one cycle, and the FSM SHALL go to IDLE; remaining pending sources are then served per REQ-022.
REQ-029 rte outside HANDLER SHALL be ignored.
REQ-030 epc and cause SHALL hold their values until the next capture; mem_addr SHALL hold until the next capture.
REQ-031 Exception entry latency SHALL be: request in IDLE at cycle t -> mem_rd at t+1 -> pc_load at t+MEM_LAT+2.

Reset
REQ-032 With reset_n=0 at a rising edge, the block SHALL go to IDLE and clear pending, the counter, mem_rd, mem_addr, epc, cause, new_pc, pc_load and exc_active to 0.
REQ-033 Reset in any state SHALL abandon the operation with no pc_load; reset SHALL take priority over all inputs.

Verification
REQ-034 Single: N_SRC=3, VEC_BASE=253, MEM_LAT=2, pc_in=0x100, exc_in=3'b010 at t -> mem_rd at t+1 with mem_addr=254, epc=0x100, cause=3'b010; mem_data=0x40 at t+3 -> pc_load with new_pc=0x40 at t+4, exc_active=1.
REQ-035 Priority: exc_in=3'b101 in one cycle -> cause=3'b001 with mem_addr=253; pending=3'b100; after rte -> pc_load with new_pc=epc, then source 2 served at address 255.
REQ-036 Mask: exc_mask=3'b011 with exc_in=3'b100 -> no mem_rd and pending=0; then unmask -> still no event.
REQ-037 No nesting / stray rte: rte in IDLE -> no pc_load; exc_in=3'b001 during HANDLER -> pending=3'b001 and no mem_rd until after RETURN.
REQ-038 Reset mid-WAIT: reset_n=0 for one edge -> all outputs 0 and pending=0; mem_data later ignored, with no pc_load.
REQ-039 MEM_LAT=1 and MEM_LAT=4 builds -> pc_load exactly MEM_LAT+2 cycles after the request.

Source files
------------

// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - vector-table read port between exception_ctrl and its memory
interface exception_ctrl_if #(
  parameter int W = 32
);
  logic         mem_rd;
  logic [W-1:0] mem_addr;
  logic [7:0]   mem_data;

  modport master (output mem_rd, output mem_addr, input mem_data);
  modport slave  (input mem_rd, input mem_addr, output mem_data);
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - prioritised exception entry/return sequencer with vector-table fetch
module exception_ctrl #(
  parameter int N_SRC    = 3,
  parameter int W        = 32,
  parameter int VEC_BASE = 253,
  parameter int MEM_LAT  = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [N_SRC-1:0]   i_exc_in,
  input  logic [N_SRC-1:0]   i_exc_mask,
  input  logic [W-1:0]       i_pc_in,
  input  logic               i_rte,
  exception_ctrl_if.master   mem,
  output logic [W-1:0]       o_epc,
  output logic [N_SRC-1:0]   o_cause,
  output logic [W-1:0]       o_new_pc,
  output logic               o_pc_load,
  output logic               o_exc_active,
  output logic [N_SRC-1:0]   o_pending
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, HANDLER, RETURN} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_SRC-1:0]   r_pending;
  logic               r_mem_rd;
  logic [W-1:0]       r_mem_addr;
  logic [W-1:0]       r_epc;
  logic [N_SRC-1:0]   r_cause;
  logic [W-1:0]       r_new_pc;
  logic               r_pc_load;
  logic               r_exc_active;

  logic [N_SRC-1:0]   w_new_req;
  logic [N_SRC-1:0]   w_req;
  logic [N_SRC-1:0]   w_sel_oh;
  logic [W-1:0]       w_sel_idx;
  logic [N_SRC-1:0]   w_clr;
  logic [N_SRC-1:0]   w_set;

  assign w_new_req = i_exc_in & i_exc_mask;
  assign w_req     = r_pending | w_new_req;

  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (w_req[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
        w_sel_idx   = W'(i);
      end
    end
  end

  // A request served straight from i_exc_in is consumed; only a repeat of an
  // already-pending source survives its own selection cycle.
  assign w_clr = (r_state == IDLE) ? w_sel_oh : '0;
  assign w_set = w_new_req & ~(w_clr & ~r_pending);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_pending    <= '0;
      r_mem_rd     <= 1'b0;
      r_mem_addr   <= '0;
      r_epc        <= '0;
      r_cause      <= '0;
      r_new_pc     <= '0;
      r_pc_load    <= 1'b0;
      r_exc_active <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      r_mem_rd  <= 1'b0;
      r_pc_load <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_epc        <= i_pc_in;
            r_cause      <= w_sel_oh;
            r_mem_addr   <= W'(VEC_BASE) + w_sel_idx;
            r_mem_rd     <= 1'b1;
            r_exc_active <= 1'b1;
            r_state      <= FETCH;
          end
        end
        FETCH: begin
          r_cnt   <= CNT_INIT;
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_new_pc  <= W'(mem.mem_data);
            r_pc_load <= 1'b1;
            r_state   <= LOAD;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        LOAD: begin
          r_state <= HANDLER;
        end
        HANDLER: begin
          if (i_rte) begin
            r_new_pc  <= r_epc;
            r_pc_load <= 1'b1;
            r_state   <= RETURN;
          end
        end
        RETURN: begin
          r_exc_active <= 1'b0;
          r_state      <= IDLE;
        end
        default: begin
          r_exc_active <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_rd   = r_mem_rd;
  assign mem.mem_addr = r_mem_addr;
  assign o_epc        = r_epc;
  assign o_cause      = r_cause;
  assign o_new_pc     = r_new_pc;
  assign o_pc_load    = r_pc_load;
  assign o_exc_active = r_exc_active;
  assign o_pending    = r_pending;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - directed self-checking bench for exception_ctrl
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  exc_in;
  logic [2:0]  exc_mask;
  logic [31:0] pc_in;
  logic        rte;

  logic [31:0] epc, new_pc, epc1, new_pc1, epc4, new_pc4;
  logic [2:0]  cause, pending, cause1, pending1, cause4, pending4;
  logic        pc_load, exc_active, pc_load1, exc_active1, pc_load4, exc_active4;

  int n_tests = 0;
  int n_fail  = 0;

  exception_ctrl_if #(.W(32)) mif  ();
  exception_ctrl_if #(.W(32)) mif1 ();
  exception_ctrl_if #(.W(32)) mif4 ();

  exception_ctrl #(.N_SRC(3), .W(32), .VEC_BASE(253), .MEM_LAT(2)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_exc_in(exc_in), .i_exc_mask(exc_mask),
    .i_pc_in(pc_in), .i_rte(rte), .mem(mif.master), .o_epc(epc), .o_cause(cause),
    .o_new_pc(new_pc), .o_pc_load(pc_load), .o_exc_active(exc_active), .o_pending(pending));

  exception_ctrl #(.N_SRC(3), .W(32), .VEC_BASE(253), .MEM_LAT(1)) dut1 (
    .i_clk(clk), .i_reset_n(reset_n), .i_exc_in(exc_in), .i_exc_mask(exc_mask),
    .i_pc_in(pc_in), .i_rte(rte), .mem(mif1.master), .o_epc(epc1), .o_cause(cause1),
    .o_new_pc(new_pc1), .o_pc_load(pc_load1), .o_exc_active(exc_active1), .o_pending(pending1));

  exception_ctrl #(.N_SRC(3), .W(32), .VEC_BASE(253), .MEM_LAT(4)) dut4 (
    .i_clk(clk), .i_reset_n(reset_n), .i_exc_in(exc_in), .i_exc_mask(exc_mask),
    .i_pc_in(pc_in), .i_rte(rte), .mem(mif4.master), .o_epc(epc4), .o_cause(cause4),
    .o_new_pc(new_pc4), .o_pc_load(pc_load4), .o_exc_active(exc_active4), .o_pending(pending4));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From the FETCH cycle: run through WAIT/LOAD into HANDLER, return, settle in IDLE.
  task automatic drain_from_fetch();
    repeat (4) tick();
    rte = 1'b1;
    tick();
    rte = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    n_tests++; if (mif.mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %0h want 0", mif.mem_rd); end
    n_tests++; if (mif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %0h want 0", mif.mem_addr); end
    n_tests++; if ({epc, new_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_pcs: got epc %0h new_pc %0h want 0", epc, new_pc); end
    n_tests++; if ({cause, pending} !== 6'h0) begin n_fail++; $display("FAIL reset_cause_pending: got %0h %0h want 0", cause, pending); end
    n_tests++; if ({pc_load, exc_active} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: got %0b want 00", {pc_load, exc_active}); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    pc_in = 32'h100; exc_in = 3'b010; mif.mem_data = 8'hFF;
    tick();
    exc_in = 3'b000;
    n_tests++; if (mif.mem_rd !== 1'b1) begin n_fail++; $display("FAIL single_mem_rd: got %0h want 1", mif.mem_rd); end
    n_tests++; if (mif.mem_addr !== 32'd254) begin n_fail++; $display("FAIL single_mem_addr: got %0d want 254", mif.mem_addr); end
    n_tests++; if (epc !== 32'h100) begin n_fail++; $display("FAIL single_epc: got %0h want 100", epc); end
    n_tests++; if (cause !== 3'b010) begin n_fail++; $display("FAIL single_cause: got %0b want 010", cause); end
    n_tests++; if (exc_active !== 1'b1) begin n_fail++; $display("FAIL single_active: got %0b want 1", exc_active); end
    tick();
    n_tests++; if ({mif.mem_rd, pc_load} !== 2'b00) begin n_fail++; $display("FAIL single_wait_strobes: got %0b want 00", {mif.mem_rd, pc_load}); end
    tick();
    mif.mem_data = 8'h40;
    n_tests++; if (pc_load !== 1'b0) begin n_fail++; $display("FAIL single_early_load: got %0b want 0", pc_load); end
    tick();
    n_tests++; if (pc_load !== 1'b1) begin n_fail++; $display("FAIL single_pc_load: got %0b want 1", pc_load); end
    n_tests++; if (new_pc !== 32'h40) begin n_fail++; $display("FAIL single_new_pc: got %0h want 40", new_pc); end
    n_tests++; if (exc_active !== 1'b1) begin n_fail++; $display("FAIL single_active_load: got %0b want 1", exc_active); end
    tick();
    n_tests++; if ({pc_load, exc_active} !== 2'b01) begin n_fail++; $display("FAIL single_handler: got %0b want 01", {pc_load, exc_active}); end
    rte = 1'b1;
    tick();
    rte = 1'b0;
    n_tests++; if (pc_load !== 1'b1 || new_pc !== 32'h100) begin n_fail++; $display("FAIL single_return: got load %0b pc %0h want 1 100", pc_load, new_pc); end
    tick();
    n_tests++; if ({pc_load, exc_active} !== 2'b00) begin n_fail++; $display("FAIL single_idle: got %0b want 00", {pc_load, exc_active}); end
  endtask

  task automatic test_priority();
    pc_in = 32'h200; exc_in = 3'b101; mif.mem_data = 8'h10;
    tick();
    exc_in = 3'b000;
    n_tests++; if (cause !== 3'b001) begin n_fail++; $display("FAIL prio_cause: got %0b want 001", cause); end
    n_tests++; if (mif.mem_addr !== 32'd253) begin n_fail++; $display("FAIL prio_addr: got %0d want 253", mif.mem_addr); end
    n_tests++; if (pending !== 3'b100) begin n_fail++; $display("FAIL prio_pending: got %0b want 100", pending); end
    repeat (3) tick();
    n_tests++; if (pc_load !== 1'b1 || new_pc !== 32'h10) begin n_fail++; $display("FAIL prio_load: got load %0b pc %0h want 1 10", pc_load, new_pc); end
    tick();
    rte = 1'b1;
    tick();
    rte = 1'b0;
    n_tests++; if (pc_load !== 1'b1 || new_pc !== 32'h200) begin n_fail++; $display("FAIL prio_return: got load %0b pc %0h want 1 200", pc_load, new_pc); end
    tick();
    n_tests++; if (exc_active !== 1'b0) begin n_fail++; $display("FAIL prio_idle_gap: got %0b want 0", exc_active); end
    tick();
    n_tests++; if (mif.mem_rd !== 1'b1 || mif.mem_addr !== 32'd255) begin n_fail++; $display("FAIL prio_second_fetch: got rd %0b addr %0d want 1 255", mif.mem_rd, mif.mem_addr); end
    n_tests++; if (cause !== 3'b100 || pending !== 3'b000) begin n_fail++; $display("FAIL prio_second_cause: got cause %0b pend %0b want 100 000", cause, pending); end
    drain_from_fetch();
  endtask

  task automatic test_mask();
    exc_mask = 3'b011; exc_in = 3'b100;
    tick();
    exc_in = 3'b000;
    n_tests++; if ({mif.mem_rd, exc_active} !== 2'b00) begin n_fail++; $display("FAIL mask_no_event: got %0b want 00", {mif.mem_rd, exc_active}); end
    n_tests++; if (pending !== 3'b000) begin n_fail++; $display("FAIL mask_pending: got %0b want 000", pending); end
    exc_mask = 3'b111;
    tick();
    tick();
    n_tests++; if ({mif.mem_rd, exc_active} !== 2'b00 || pending !== 3'b000) begin n_fail++; $display("FAIL mask_unmask: got rd/act %0b pend %0b want 00 000", {mif.mem_rd, exc_active}, pending); end
  endtask

  task automatic test_no_nesting();
    rte = 1'b1;
    tick();
    rte = 1'b0;
    n_tests++; if ({pc_load, exc_active} !== 2'b00) begin n_fail++; $display("FAIL stray_rte: got %0b want 00", {pc_load, exc_active}); end
    pc_in = 32'h300; exc_in = 3'b010; mif.mem_data = 8'h55;
    tick();
    exc_in = 3'b000;
    repeat (4) tick();
    exc_in = 3'b001;
    tick();
    exc_in = 3'b000;
    n_tests++; if (pending !== 3'b001) begin n_fail++; $display("FAIL nest_pending: got %0b want 001", pending); end
    n_tests++; if (mif.mem_rd !== 1'b0 || cause !== 3'b010) begin n_fail++; $display("FAIL nest_no_fetch: got rd %0b cause %0b want 0 010", mif.mem_rd, cause); end
    tick();
    n_tests++; if (mif.mem_rd !== 1'b0 || exc_active !== 1'b1) begin n_fail++; $display("FAIL nest_hold: got rd %0b act %0b want 0 1", mif.mem_rd, exc_active); end
    rte = 1'b1;
    tick();
    rte = 1'b0;
    n_tests++; if (pc_load !== 1'b1 || new_pc !== 32'h300) begin n_fail++; $display("FAIL nest_return: got load %0b pc %0h want 1 300", pc_load, new_pc); end
    tick();
    tick();
    n_tests++; if (mif.mem_rd !== 1'b1 || cause !== 3'b001 || mif.mem_addr !== 32'd253) begin n_fail++; $display("FAIL nest_served: got rd %0b cause %0b addr %0d want 1 001 253", mif.mem_rd, cause, mif.mem_addr); end
    drain_from_fetch();
  endtask

  task automatic test_reset_mid_wait();
    logic saw_load;
    saw_load = 1'b0;
    pc_in = 32'h400; exc_in = 3'b001; mif.mem_data = 8'h00;
    tick();
    exc_in = 3'b000;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_tests++; if ({mif.mem_rd, pc_load, exc_active} !== 3'b000 || mif.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_wait_strobes: got %0b addr %0h want 000 0", {mif.mem_rd, pc_load, exc_active}, mif.mem_addr); end
    n_tests++; if ({epc, new_pc} !== 64'h0 || {cause, pending} !== 6'h0) begin n_fail++; $display("FAIL rst_wait_regs: got epc %0h pc %0h cause %0b pend %0b want 0", epc, new_pc, cause, pending); end
    mif.mem_data = 8'h77;
    for (int k = 0; k < 5; k++) begin
      saw_load = saw_load | pc_load;
      tick();
    end
    n_tests++; if (saw_load !== 1'b0 || new_pc !== 32'h0) begin n_fail++; $display("FAIL rst_wait_ignored: got load %0b pc %0h want 0 0", saw_load, new_pc); end
  endtask

  task automatic test_latency();
    int first2, first1, first4, cnt2, cnt1, cnt4;
    first2 = 0; first1 = 0; first4 = 0; cnt2 = 0; cnt1 = 0; cnt4 = 0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    mif.mem_data = 8'h22; mif1.mem_data = 8'h21; mif4.mem_data = 8'h24;
    exc_in = 3'b001;
    tick();
    exc_in = 3'b000;
    for (int k = 1; k <= 8; k++) begin
      if (pc_load === 1'b1) begin cnt2++; if (first2 == 0) first2 = k; end
      if (pc_load1 === 1'b1) begin cnt1++; if (first1 == 0) first1 = k; end
      if (pc_load4 === 1'b1) begin cnt4++; if (first4 == 0) first4 = k; end
      tick();
    end
    n_tests++; if (first1 != 3 || cnt1 != 1) begin n_fail++; $display("FAIL lat1: got cycle %0d count %0d want 3 1", first1, cnt1); end
    n_tests++; if (first2 != 4 || cnt2 != 1) begin n_fail++; $display("FAIL lat2: got cycle %0d count %0d want 4 1", first2, cnt2); end
    n_tests++; if (first4 != 6 || cnt4 != 1) begin n_fail++; $display("FAIL lat4: got cycle %0d count %0d want 6 1", first4, cnt4); end
    n_tests++; if (new_pc1 !== 32'h21 || new_pc4 !== 32'h24) begin n_fail++; $display("FAIL lat_data: got %0h %0h want 21 24", new_pc1, new_pc4); end
    rte = 1'b1;
    tick();
    rte = 1'b0;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; exc_in = 3'b000; exc_mask = 3'b111; pc_in = 32'h0; rte = 1'b0;
    mif.mem_data = 8'h00; mif1.mem_data = 8'h00; mif4.mem_data = 8'h00;
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_no_nesting();
    test_reset_mid_wait();
    test_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
